// File: rtl/pi_loop_controller.sv
// PI loop sequencer: arms the ADC, drives the PI pipeline, clamps the result to the
// DAC range with integral anti-windup, and reports loop status.
module pi_loop_controller #(
  parameter int unsigned INPUT_WIDTH       = 18,
  parameter int unsigned OUTPUT_WIDTH      = 32,
  parameter int unsigned OUTPUT_RANGE_BITS = 20,
  parameter int unsigned PERIOD_WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  input  logic                         integral_clear_i,
  input  logic [PERIOD_WIDTH-1:0]      period_i,
  input  logic [OUTPUT_WIDTH-1:0]      kp_i,
  input  logic [OUTPUT_WIDTH-1:0]      ki_i,
  input  logic [INPUT_WIDTH-1:0]       setpoint_i,
  output logic                         adc_arm_o,
  input  logic                         adc_finished_i,
  input  logic [INPUT_WIDTH-1:0]       adc_data_i,
  output logic                         pi_cyc_o,
  output logic [OUTPUT_WIDTH-1:0]      pi_kp_o,
  output logic [OUTPUT_WIDTH-1:0]      pi_ki_o,
  output logic [OUTPUT_WIDTH-1:0]      pi_integral_input_o,
  output logic [INPUT_WIDTH-1:0]       pi_setpoint_o,
  output logic [INPUT_WIDTH-1:0]       pi_actual_o,
  input  logic                         pi_result_valid_i,
  input  logic                         pi_overflow_i,
  input  logic                         pi_underflow_i,
  input  logic [OUTPUT_WIDTH-1:0]      pi_result_i,
  input  logic [OUTPUT_WIDTH-1:0]      pi_integral_result_i,
  output logic                         dac_arm_o,
  input  logic                         dac_finished_i,
  output logic [OUTPUT_RANGE_BITS-1:0] dac_data_o,
  output logic                         running_o,
  output logic                         saturated_o,
  output logic [OUTPUT_WIDTH-1:0]      integral_o,
  output logic [31:0]                  iter_count_o
);

  localparam int unsigned ITER_WIDTH = 32;
  localparam int unsigned R          = OUTPUT_RANGE_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADC   = 3'd1;
  localparam logic [2:0] S_PIPE  = 3'd2;
  localparam logic [2:0] S_CLAMP = 3'd3;
  localparam logic [2:0] S_DAC   = 3'd4;

  localparam logic [R-1:0] DAC_MAX = {1'b0, {(R-1){1'b1}}};
  localparam logic [R-1:0] DAC_MIN = {1'b1, {(R-1){1'b0}}};

  logic [2:0]              state_q, state_d;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                    adc_arm_q, adc_arm_d;
  logic                    dac_arm_q, dac_arm_d;
  logic                    pi_cyc_q, pi_cyc_d;
  logic [OUTPUT_WIDTH-1:0] pi_kp_q, pi_kp_d;
  logic [OUTPUT_WIDTH-1:0] pi_ki_q, pi_ki_d;
  logic [INPUT_WIDTH-1:0]  pi_setpoint_q, pi_setpoint_d;
  logic [INPUT_WIDTH-1:0]  pi_actual_q, pi_actual_d;
  logic [R-1:0]            res_q, res_d;
  logic [OUTPUT_WIDTH-1:0] ires_q, ires_d;
  logic                    ov_q, ov_d;
  logic                    un_q, un_d;
  logic [R-1:0]            dac_data_q, dac_data_d;
  logic                    saturated_q, saturated_d;
  logic [OUTPUT_WIDTH-1:0] integral_q, integral_d;
  logic [ITER_WIDTH-1:0]   iter_count_q, iter_count_d;
  logic                    running_q, running_d;

  // Only the DAC-range slice of the pipeline result is ever driven out.
  logic unused_result_hi;
  assign unused_result_hi = ^pi_result_i[OUTPUT_WIDTH-1:R];

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + PERIOD_WIDTH'(1);
    adc_arm_d     = adc_arm_q;
    dac_arm_d     = dac_arm_q;
    pi_cyc_d      = pi_cyc_q;
    pi_kp_d       = pi_kp_q;
    pi_ki_d       = pi_ki_q;
    pi_setpoint_d = pi_setpoint_q;
    pi_actual_d   = pi_actual_q;
    res_d         = res_q;
    ires_d        = ires_q;
    ov_d          = ov_q;
    un_d          = un_q;
    dac_data_d    = dac_data_q;
    saturated_d   = saturated_q;
    integral_d    = integral_q;
    iter_count_d  = iter_count_q;

    case (state_q)
      S_IDLE: begin
        if (enable_i && (period_cnt_q >= period_i)) begin
          state_d       = S_ADC;
          pi_kp_d       = kp_i;
          pi_ki_d       = ki_i;
          pi_setpoint_d = setpoint_i;
          // The start clock itself counts, so starts are exactly 'period' clocks apart.
          period_cnt_d  = PERIOD_WIDTH'(1);
          adc_arm_d     = 1'b1;
        end
      end
      S_ADC: begin
        if (adc_finished_i) begin
          pi_actual_d = adc_data_i;
          adc_arm_d   = 1'b0;
          pi_cyc_d    = 1'b1;
          state_d     = S_PIPE;
        end
      end
      S_PIPE: begin
        if (pi_result_valid_i) begin
          res_d    = pi_result_i[R-1:0];
          ires_d   = pi_integral_result_i;
          ov_d     = pi_overflow_i;
          un_d     = pi_underflow_i;
          pi_cyc_d = 1'b0;
          state_d  = S_CLAMP;
        end
      end
      S_CLAMP: begin
        if (ov_q) begin
          dac_data_d = DAC_MAX;
        end else if (un_q) begin
          dac_data_d = DAC_MIN;
        end else begin
          dac_data_d = res_q;
        end
        saturated_d = ov_q | un_q;
        // Anti-windup: a clamped iteration leaves the stored integral untouched.
        if (!(ov_q | un_q)) begin
          integral_d = ires_q;
        end
        dac_arm_d = 1'b1;
        state_d   = S_DAC;
      end
      S_DAC: begin
        if (dac_finished_i) begin
          dac_arm_d    = 1'b0;
          iter_count_d = iter_count_q + ITER_WIDTH'(1);
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        adc_arm_d = 1'b0;
        dac_arm_d = 1'b0;
        pi_cyc_d  = 1'b0;
      end
    endcase

    if (integral_clear_i) begin
      integral_d = '0;
    end
    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      period_cnt_q  <= '1;
      adc_arm_q     <= 1'b0;
      dac_arm_q     <= 1'b0;
      pi_cyc_q      <= 1'b0;
      pi_kp_q       <= '0;
      pi_ki_q       <= '0;
      pi_setpoint_q <= '0;
      pi_actual_q   <= '0;
      res_q         <= '0;
      ires_q        <= '0;
      ov_q          <= 1'b0;
      un_q          <= 1'b0;
      dac_data_q    <= '0;
      saturated_q   <= 1'b0;
      integral_q    <= '0;
      iter_count_q  <= '0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      adc_arm_q     <= adc_arm_d;
      dac_arm_q     <= dac_arm_d;
      pi_cyc_q      <= pi_cyc_d;
      pi_kp_q       <= pi_kp_d;
      pi_ki_q       <= pi_ki_d;
      pi_setpoint_q <= pi_setpoint_d;
      pi_actual_q   <= pi_actual_d;
      res_q         <= res_d;
      ires_q        <= ires_d;
      ov_q          <= ov_d;
      un_q          <= un_d;
      dac_data_q    <= dac_data_d;
      saturated_q   <= saturated_d;
      integral_q    <= integral_d;
      iter_count_q  <= iter_count_d;
      running_q     <= running_d;
    end
  end

  assign adc_arm_o           = adc_arm_q;
  assign dac_arm_o           = dac_arm_q;
  assign pi_cyc_o            = pi_cyc_q;
  assign pi_kp_o             = pi_kp_q;
  assign pi_ki_o             = pi_ki_q;
  assign pi_setpoint_o       = pi_setpoint_q;
  assign pi_actual_o         = pi_actual_q;
  assign pi_integral_input_o = integral_q;
  assign dac_data_o          = dac_data_q;
  assign saturated_o         = saturated_q;
  assign integral_o          = integral_q;
  assign iter_count_o        = iter_count_q;
  assign running_o           = running_q;

endmodule
